video_dither_rgb6: RTL and testbench
====================================

Name: video_dither_rgb6

Overview:
- Downstream video stage between the guest core's 8-bit-per-channel RGB output and the board's 6-bit VGA pins.
- Reduces each of R/G/B from 8 to 6 bits using 2x2 ordered (Bayer) dither, with optional per-frame temporal inversion of the pattern.
- Delays HS/VS/DE through the same pipeline so sync and colour stay aligned.
- Replaces plain truncation (taking bits [7:2]) on 6-bit boards.

Parameters:
- TEMPORAL, 1: when 1, the dither pattern is inverted on alternate frames; when 0, the pattern is static.

Ports:
- clk  in  1  system/pixel-domain clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- pix_ce  in  1  pixel clock enable; all state advances only on clk edges with pix_ce=1.
- dither_en  in  1  1 = dither; 0 = plain truncation (in[7:2]).
- r_in, g_in, b_in  in  8 each  input colour.
- hs_in, vs_in  in  1 each  input syncs, any polarity, passed through unchanged.
- de_in  in  1  active-video flag, 1 = visible pixel.
- r_out, g_out, b_out  out  6 each  output colour.
- hs_out, vs_out, de_out  out  1 each  delayed syncs and DE.

Behaviour:
- Reset (synchronous, overrides pix_ce):
  - all outputs are 0;
  - pipeline registers are 0;
  - x_par, y_par and f_par are 0;
  - the edge-detect history registers are 0.
- Latency: exactly 2 pix_ce-qualified clocks, from input sample to output, identical for colour, hs, vs and de.
- Stall: when pix_ce=0, every register holds, including all outputs and all counters.
- Stage 1, on a pix_ce edge:
  - register r/g/b_in, hs/vs/de_in and dither_en;
  - compute the threshold t (2 bits) for this pixel from the current x_par, y_par and f_par.
- Threshold matrix M[row][col]: M[0][0]=0, M[0][1]=2, M[1][0]=3, M[1][1]=1.
  - row = y_par XOR (f_par AND TEMPORAL).
  - col = x_par XOR (f_par AND TEMPORAL).
- Stage 2, on a pix_ce edge, for each channel c:
  - if de=0: c_out = 0 (blanking forced to black);
  - else if dither_en=0: c_out = c[7:2];
  - else: s = {1'b0,c} + t (9 bits); c_out = 63 if s[8]=1, else s[7:2]. The saturation case is only reachable at c >= 253.
  - hs_out, vs_out and de_out take their stage-1 values.
- Position counters are updated on pix_ce edges using the current input values:
  - x_par: toggles after each pixel with de_in=1; forced to 0 whenever de_in=0. The first visible pixel of every line uses x_par=0.
  - y_par: toggles on each de_in falling edge (previous de_in=1, current de_in=0).
  - Frame boundary is a vs_in rising edge (previous vs_in=0, current vs_in=1). On it: y_par is cleared to 0, and f_par toggles if TEMPORAL=1 (stays 0 otherwise).
  - If a de_in falling edge and a vs rising edge occur on the same pix_ce, the frame clear wins: y_par=0.
- Changing dither_en mid-line takes effect at the pixel it is sampled with; there is no glitch on sync outputs.
- Reset asserted mid-frame: outputs go to 0 on the next clk edge regardless of pix_ce. The pattern restarts at x=y=f=0. The first two pix_ce outputs after reset release reflect the zeroed pipeline (de_out=0, colours 0).
- The three channels share one t per pixel; no per-channel offset.

Test Plan:
- Reset: drive random inputs with pix_ce=1 and assert reset for 3 clocks -> all outputs 0 throughout; de_out stays 0 for the first 2 pix_ce after release.
- Truncation: dither_en=0, de_in=1, r/g/b=0xAB/0x03/0xFF -> r/g/b_out = 0x2A/0x00/0x3F exactly 2 pix_ce later.
- Pattern, TEMPORAL=1, frame 0, flat 0x81 on all channels:
  - line 0 outputs 0x20,0x20 repeating;
  - line 1 outputs 0x21,0x20 repeating;
  - after one vs_in rising edge (frame 1), line 0 outputs 0x20,0x21 repeating and line 1 outputs 0x20,0x20 repeating.
- Saturation: flat 0xFF with dither_en=1 over 2 lines x 2 pixels -> every output 0x3F, never 0x00. Flat 0xFD at line 1 x0 (t=3) -> 0x3F.
- Stall and sync alignment:
  - insert pix_ce low for 5 clocks mid-line -> outputs and counters hold, and the pattern resumes at the correct phase;
  - a 1-pixel hs_in pulse appears on hs_out exactly 2 pix_ce later with an identical width in pix_ce units;
  - de_in=0 pixels output 0 colour.
- Simultaneous events: de_in falls on the same pix_ce as a vs_in rising edge -> the next visible line starts with y_par=0 (first pixel t=0 in frame with f_par=0).

Source files
------------

// File: rtl/video_dither_rgb6.sv
// -----------------------------------------------------------------------------
// video_dither_rgb6
//
// Purpose:
//   Reduces an 8-bit-per-channel RGB pixel stream to 6 bits per channel for
//   boards with 6-bit VGA DACs. It uses a 2x2 ordered (Bayer) dither instead
//   of plain truncation. When TEMPORAL=1, the pattern is inverted on
//   alternate frames so the residual texture averages out over time. HS, VS
//   and DE pass through the same two-stage pipeline, so sync and colour stay
//   aligned.
//
// Parameters:
//   TEMPORAL  1 = invert the dither pattern every frame, 0 = static pattern
//
// Ports:
//   clk                   pixel-domain clock (only clock)
//   reset                 synchronous, active-high reset
//   pix_ce                pixel clock enable; all state advances only when 1
//   dither_en             1 = ordered dither, 0 = truncation (in[7:2])
//   r_in, g_in, b_in      8-bit input colour
//   hs_in, vs_in, de_in   input syncs (any polarity) and active-video flag
//   r_out, g_out, b_out   6-bit output colour, 2 pix_ce after input
//   hs_out, vs_out, de_out  syncs and DE delayed by the same 2 pix_ce
// -----------------------------------------------------------------------------
module video_dither_rgb6 #(
    parameter bit TEMPORAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       dither_en,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       de_in,
    output logic [5:0] r_out,
    output logic [5:0] g_out,
    output logic [5:0] b_out,
    output logic       hs_out,
    output logic       vs_out,
    output logic       de_out
);

    localparam int NCH = 3;   // channel index 2 = R, 1 = G, 0 = B

    // ------------------------------------------------------------------
    // Channel-packed view of the input colour
    // ------------------------------------------------------------------
    logic [NCH-1:0][7:0] pix_in;
    assign pix_in = {r_in, g_in, b_in};

    // ------------------------------------------------------------------
    // Position / frame parity counters and edge-detect history
    // ------------------------------------------------------------------
    logic x_par_q,   x_par_d;
    logic y_par_q,   y_par_d;
    logic f_par_q,   f_par_d;
    logic de_prev_q, de_prev_d;
    logic vs_prev_q, vs_prev_d;

    logic de_fall;
    logic vs_rise;
    logic temporal_flip;

    // Stage 1 registers
    logic [NCH-1:0][7:0] pix1_q, pix1_d;
    logic                hs1_q,  hs1_d;
    logic                vs1_q,  vs1_d;
    logic                de1_q,  de1_d;
    logic                en1_q,  en1_d;
    logic [1:0]          t1_q,   t1_d;

    // Stage 2 (output) registers
    logic [NCH-1:0][5:0] pix2_q, pix2_d;
    logic                hs2_q,  hs2_d;
    logic                vs2_q,  vs2_d;
    logic                de2_q,  de2_d;

    // ------------------------------------------------------------------
    // Counter next-state. The counters look at the live inputs of the
    // pixel being sampled, while the threshold for that same pixel uses
    // the values from before the update.
    // ------------------------------------------------------------------
    always_comb begin
        de_fall   = de_prev_q & ~de_in;
        vs_rise   = ~vs_prev_q & vs_in;

        // The first visible pixel of every line must see x_par=0, so any
        // blanking pixel parks the column parity at 0.
        x_par_d   = de_in ? ~x_par_q : 1'b0;

        // A frame start takes priority over the end of a line, so a line
        // ending on the vs edge does not leave the new frame on row 1.
        y_par_d   = y_par_q;
        if (vs_rise) begin
            y_par_d = 1'b0;
        end else if (de_fall) begin
            y_par_d = ~y_par_q;
        end

        // With TEMPORAL=0 this term is constant 0, so f_par stays 0.
        f_par_d   = f_par_q ^ (vs_rise & TEMPORAL);

        de_prev_d = de_in;
        vs_prev_d = vs_in;
    end

    // ------------------------------------------------------------------
    // Threshold lookup. On odd frames the row and column are both
    // inverted, which is equivalent to rotating the 2x2 matrix by 180
    // degrees. Every pixel then gets the threshold of its diagonal
    // neighbour.
    // ------------------------------------------------------------------
    assign temporal_flip = f_par_q & TEMPORAL;

    always_comb begin
        logic row;
        logic col;
        row = y_par_q ^ temporal_flip;
        col = x_par_q ^ temporal_flip;
        unique case ({row, col})
            2'b00:   t1_d = 2'd0;
            2'b01:   t1_d = 2'd2;
            2'b10:   t1_d = 2'd3;
            default: t1_d = 2'd1;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 1 capture
    // ------------------------------------------------------------------
    always_comb begin
        pix1_d = pix_in;
        hs1_d  = hs_in;
        vs1_d  = vs_in;
        de1_d  = de_in;
        en1_d  = dither_en;
    end

    // ------------------------------------------------------------------
    // Stage 2: per-channel dither / truncate / blank.
    // Adding t (0..3) to c and keeping bits [8:2] is done as follows:
    // a carry is formed out of the two low bits, then added to c[7:2].
    // The only way to overflow 6 bits is c[7:2]=63 with a carry, which
    // saturates to 63. This is reachable only for c >= 253.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic       carry;
            logic [6:0] sum_hi;
            logic [5:0] ch_out;

            always_comb begin
                carry  = (({1'b0, pix1_q[gi][1:0]} + {1'b0, t1_q}) > 3'd3);
                sum_hi = {1'b0, pix1_q[gi][7:2]} + {6'd0, carry};

                if (!de1_q) begin
                    ch_out = 6'd0;                  // blanking forced to black
                end else if (!en1_q) begin
                    ch_out = pix1_q[gi][7:2];
                end else if (sum_hi[6]) begin
                    ch_out = 6'h3F;
                end else begin
                    ch_out = sum_hi[5:0];
                end
            end

            assign pix2_d[gi] = ch_out;
        end
    endgenerate

    always_comb begin
        hs2_d = hs1_q;
        vs2_d = vs1_q;
        de2_d = de1_q;
    end

    // ------------------------------------------------------------------
    // State registers. Reset overrides pix_ce; otherwise everything holds
    // while pix_ce is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            x_par_q   <= 1'b0;
            y_par_q   <= 1'b0;
            f_par_q   <= 1'b0;
            de_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            pix1_q    <= '0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            de1_q     <= 1'b0;
            en1_q     <= 1'b0;
            t1_q      <= 2'd0;
            pix2_q    <= '0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
            de2_q     <= 1'b0;
        end else if (pix_ce) begin
            x_par_q   <= x_par_d;
            y_par_q   <= y_par_d;
            f_par_q   <= f_par_d;
            de_prev_q <= de_prev_d;
            vs_prev_q <= vs_prev_d;
            pix1_q    <= pix1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            de1_q     <= de1_d;
            en1_q     <= en1_d;
            t1_q      <= t1_d;
            pix2_q    <= pix2_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            de2_q     <= de2_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from the stage-2 registers
    // ------------------------------------------------------------------
    assign r_out  = pix2_q[2];
    assign g_out  = pix2_q[1];
    assign b_out  = pix2_q[0];
    assign hs_out = hs2_q;
    assign vs_out = vs2_q;
    assign de_out = de2_q;

endmodule

// File: tb/tb_video_dither_rgb6.sv
// -----------------------------------------------------------------------------
// tb_video_dither_rgb6
//
// Table-driven bench for video_dither_rgb6 (TEMPORAL=1). Each table record
// holds one pixel's inputs and the hand-computed 6-bit colour it must
// produce. When the pixel is driven, its expected output (colour plus the
// same hs/vs/de) is pushed to a scoreboard queue. After each pix_ce edge,
// the oldest entry is popped and compared. The queue is seeded with one
// zero entry after reset, which models the two-stage latency and the
// zeroed pipeline.
// -----------------------------------------------------------------------------
module tb_video_dither_rgb6;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_ce;
    logic       dither_en;
    logic [7:0] r_in, g_in, b_in;
    logic       hs_in, vs_in, de_in;
    logic [5:0] r_out, g_out, b_out;
    logic       hs_out, vs_out, de_out;

    always #5 clk = ~clk;

    video_dither_rgb6 #(.TEMPORAL(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_ce    (pix_ce),
        .dither_en (dither_en),
        .r_in      (r_in),
        .g_in      (g_in),
        .b_in      (b_in),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .de_in     (de_in),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .de_out    (de_out)
    );

    typedef struct packed {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
        logic       hs;
        logic       vs;
        logic       de;
    } out_t;

    typedef struct {
        logic       de, vs, hs, en;
        logic [7:0] r, g, b;
        logic [5:0] er, eg, eb;
        int         stall;   // pix_ce-low clocks inserted before this pixel
    } vec_t;

    vec_t main_tbl[$];
    vec_t restart_tbl[$];
    out_t sb[$];
    out_t last_exp;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic de, input logic vs, input logic hs,
                                input logic en, input logic [7:0] r,
                                input logic [7:0] g, input logic [7:0] b,
                                input logic [5:0] er, input logic [5:0] eg,
                                input logic [5:0] eb, input int stall);
        vec_t v;
        v.de = de; v.vs = vs; v.hs = hs; v.en = en;
        v.r = r; v.g = g; v.b = b;
        v.er = er; v.eg = eg; v.eb = eb;
        v.stall = stall;
        return v;
    endfunction

    task automatic check(input string name, input out_t e);
        out_t got;
        got = {r_out, g_out, b_out, hs_out, vs_out, de_out};
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s: got rgb=%h/%h/%h hs/vs/de=%b%b%b, want rgb=%h/%h/%h hs/vs/de=%b%b%b",
                     name, got.r, got.g, got.b, got.hs, got.vs, got.de,
                     e.r, e.g, e.b, e.hs, e.vs, e.de);
        end else begin
            $display("ok   %s: rgb=%h/%h/%h hs/vs/de=%b%b%b",
                     name, got.r, got.g, got.b, got.hs, got.vs, got.de);
        end
    endtask

    task automatic randomize_inputs();
        r_in      = 8'($urandom);
        g_in      = 8'($urandom);
        b_in      = 8'($urandom);
        hs_in     = 1'($urandom_range(0, 1));
        vs_in     = 1'($urandom_range(0, 1));
        de_in     = 1'($urandom_range(0, 1));
        dither_en = 1'($urandom_range(0, 1));
    endtask

    // Apply one pixel on a pix_ce edge. Any requested stall clocks come
    // first; during those, the inputs carry garbage, and the outputs must
    // keep the last value.
    task automatic apply(input vec_t v, input string name);
        out_t e;
        for (int s = 0; s < v.stall; s++) begin
            pix_ce = 1'b0;
            randomize_inputs();
            @(posedge clk); #1;
            check($sformatf("%s_stall%0d", name, s), last_exp);
        end
        pix_ce    = 1'b1;
        dither_en = v.en;
        de_in     = v.de;
        vs_in     = v.vs;
        hs_in     = v.hs;
        r_in      = v.r;
        g_in      = v.g;
        b_in      = v.b;
        e = {v.er, v.eg, v.eb, v.hs, v.vs, v.de};
        sb.push_back(e);
        @(posedge clk); #1;
        pix_ce = 1'b0;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got nothing to compare, want one entry", name);
        end else begin
            last_exp = sb.pop_front();
            check(name, last_exp);
        end
    endtask

    // Hold reset for n clocks with random inputs. One of those clocks has
    // pix_ce low to show that reset does not wait for the enable.
    task automatic do_reset(input string name, input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            pix_ce = (i == 1) ? 1'b0 : 1'b1;
            randomize_inputs();
            @(posedge clk); #1;
            check($sformatf("%s%0d", name, i), '0);
        end
        reset  = 1'b0;
        pix_ce = 1'b0;
        de_in  = 1'b0;
        vs_in  = 1'b0;
        hs_in  = 1'b0;
        sb.delete();
        sb.push_back('0);
        last_exp = '0;
    endtask

    initial begin
        reset = 1'b0; pix_ce = 1'b0; dither_en = 1'b0;
        r_in = '0; g_in = '0; b_in = '0;
        hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b0;

        // ---------------- main table ----------------
        //              de vs hs en  r      g      b      er     eg     eb    stall
        // frame 0, line 0: t = 0,2 -> 0x81 -> 0x20,0x20
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20, 0)); // v0
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20, 0)); // v1
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20, 0)); // v2
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20, 0)); // v3
        // blanking with a 1-pixel hs pulse; colour forced to 0
        main_tbl.push_back(mk(0, 0, 1, 1, 8'h81, 8'h81, 8'h81, 6'h00, 6'h00, 6'h00, 0)); // v4
        main_tbl.push_back(mk(0, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h00, 6'h00, 6'h00, 0)); // v5
        // frame 0, line 1: t = 3,1 -> 0x21,0x20; 5-clock stall mid-line
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h21, 6'h21, 6'h21, 0)); // v6
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20, 0)); // v7
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h21, 6'h21, 6'h21, 5)); // v8
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20, 0)); // v9
        main_tbl.push_back(mk(0, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h00, 6'h00, 6'h00, 0)); // v10
        // vs rising edge -> frame 1
        main_tbl.push_back(mk(0, 1, 0, 1, 8'h81, 8'h81, 8'h81, 6'h00, 6'h00, 6'h00, 0)); // v11
        main_tbl.push_back(mk(0, 1, 0, 1, 8'h81, 8'h81, 8'h81, 6'h00, 6'h00, 6'h00, 0)); // v12
        main_tbl.push_back(mk(0, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h00, 6'h00, 6'h00, 0)); // v13
        // frame 1, line 0: t = 1,3 -> 0x20,0x21
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20, 0)); // v14
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h21, 6'h21, 6'h21, 0)); // v15
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20, 0)); // v16
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h21, 6'h21, 6'h21, 0)); // v17
        main_tbl.push_back(mk(0, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h00, 6'h00, 6'h00, 0)); // v18
        // frame 1, line 1: t = 2,0 -> 0x20,0x20; then t=2 with mixed channels
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20, 0)); // v19
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20, 0)); // v20
        main_tbl.push_back(mk(1, 0, 0, 1, 8'hFD, 8'hFF, 8'h00, 6'h3F, 6'h3F, 6'h00, 0)); // v21
        main_tbl.push_back(mk(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 6'h00, 6'h00, 6'h00, 0)); // v22
        // vs rising edge -> frame 2 (f_par back to 0)
        main_tbl.push_back(mk(0, 1, 0, 1, 8'hFF, 8'hFF, 8'hFF, 6'h00, 6'h00, 6'h00, 0)); // v23
        main_tbl.push_back(mk(0, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF, 6'h00, 6'h00, 6'h00, 0)); // v24
        // saturation: 0xFF over 2x2 -> all 0x3F; 0xFD at line 1 x0 (t=3) -> 0x3F
        main_tbl.push_back(mk(1, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF, 6'h3F, 6'h3F, 6'h3F, 0)); // v25
        main_tbl.push_back(mk(1, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF, 6'h3F, 6'h3F, 6'h3F, 0)); // v26
        main_tbl.push_back(mk(0, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF, 6'h00, 6'h00, 6'h00, 0)); // v27
        main_tbl.push_back(mk(1, 0, 0, 1, 8'hFD, 8'hFF, 8'hFF, 6'h3F, 6'h3F, 6'h3F, 0)); // v28
        main_tbl.push_back(mk(1, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF, 6'h3F, 6'h3F, 6'h3F, 0)); // v29
        main_tbl.push_back(mk(0, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF, 6'h00, 6'h00, 6'h00, 0)); // v30
        // truncation, then dither_en toggled per pixel within the line
        main_tbl.push_back(mk(1, 0, 0, 0, 8'hAB, 8'h03, 8'hFF, 6'h2A, 6'h00, 6'h3F, 0)); // v31
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h81, 8'h82, 8'h83, 6'h20, 6'h21, 6'h21, 0)); // v32
        main_tbl.push_back(mk(1, 0, 0, 0, 8'h81, 8'h82, 8'h83, 6'h20, 6'h20, 6'h20, 0)); // v33
        // de falls on the same pixel as a vs rising edge: y_par must be 0
        main_tbl.push_back(mk(0, 1, 0, 1, 8'h82, 8'h82, 8'h82, 6'h00, 6'h00, 6'h00, 0)); // v34
        main_tbl.push_back(mk(0, 0, 0, 1, 8'h82, 8'h82, 8'h82, 6'h00, 6'h00, 6'h00, 0)); // v35
        // frame 3 (f=1), row 0: t = 1,3 -> 0x82 -> 0x20,0x21 (row 1 would give 0x21 first)
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h82, 8'h82, 8'h82, 6'h20, 6'h20, 6'h20, 0)); // v36
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h82, 8'h82, 8'h82, 6'h21, 6'h21, 6'h21, 0)); // v37
        main_tbl.push_back(mk(0, 0, 0, 1, 8'h82, 8'h82, 8'h82, 6'h00, 6'h00, 6'h00, 0)); // v38
        main_tbl.push_back(mk(0, 0, 0, 1, 8'h82, 8'h82, 8'h82, 6'h00, 6'h00, 6'h00, 0)); // v39
        // mid-frame (f=1, row 1): t = 2,0 -> 0x21,0x20; reset cuts in afterwards
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h82, 8'h82, 8'h82, 6'h21, 6'h21, 6'h21, 0)); // v40
        main_tbl.push_back(mk(1, 0, 0, 1, 8'h82, 8'h82, 8'h82, 6'h20, 6'h20, 6'h20, 0)); // v41

        // after reset the pattern restarts at x=y=f=0: t = 0,2 -> 0x20,0x21
        restart_tbl.push_back(mk(1, 0, 0, 1, 8'h82, 8'h82, 8'h82, 6'h20, 6'h20, 6'h20, 0));
        restart_tbl.push_back(mk(1, 0, 0, 1, 8'h82, 8'h82, 8'h82, 6'h21, 6'h21, 6'h21, 0));
        restart_tbl.push_back(mk(0, 0, 0, 1, 8'h82, 8'h82, 8'h82, 6'h00, 6'h00, 6'h00, 0));
        restart_tbl.push_back(mk(0, 0, 0, 1, 8'h82, 8'h82, 8'h82, 6'h00, 6'h00, 6'h00, 0));

        // ---------------- run ----------------
        @(posedge clk); #1;
        do_reset("reset", 4);
        check("post_reset_idle", '0);

        foreach (main_tbl[i]) begin
            apply(main_tbl[i], $sformatf("vec%0d", i));
        end

        // mid-frame reset, then the pattern must restart from phase 0
        do_reset("midreset", 3);
        foreach (restart_tbl[i]) begin
            apply(restart_tbl[i], $sformatf("restart%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog: the stimulus is fixed-length, so this only trips on a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running at %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
